pipeline_memory_stage: RTL and testbench

Memory-access stage that consumes the EX/MEM pipeline register outputs and produces the MEM/WB register. It performs data-memory loads and stores over a 32-bit req/ack bus, splits 64-bit vector accesses into two beats and stalls the front of the pipeline while an access is in flight. Non-memory instructions pass straight through to writeback with one cycle of latency.

---
 rtl/pipeline_memory_stage.sv | 206 ++++++++++++++++++++
 tb/tb_pipeline_memory_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_memory_stage.sv
// pipeline_memory_stage
// MEM stage: consumes EX/MEM, performs data-memory loads/stores over a 32-bit
// req/ack bus (64-bit vector accesses take two beats), stalls the front of the
// pipeline while an access is in flight, and produces the MEM/WB register.
module pipeline_memory_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        wEnMemPipeEx_Out,
    input  logic [1:0]        wEnRegPipeEx_Out,
    input  logic [3:0]        rdPipeEx_Out,
    input  logic              memoryMuxSelPipeEx_Out,
    input  logic              readModeMemPipeEx_Out,
    input  logic [63:0]       aluRes_pipeExOut,
    input  logic [63:0]       regData2_pipeExOut,
    output logic              memStall,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWdata,
    input  logic              memAck,
    input  logic [31:0]       memRdata,
    output logic [1:0]        wEnRegPipeMem_Out,
    output logic [3:0]        rdPipeMem_Out,
    output logic [63:0]       wbDataPipeMem_Out
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    state_t state, state_nxt;

    // Decode of the instruction currently sitting in EX/MEM. A store wins over
    // memoryMuxSel, so a store+load combination behaves as a plain store.
    logic              is_store, is_load, is_vec, memop;
    logic [ADDR_W-1:0] addr_aligned;

    assign is_store     = (wEnMemPipeEx_Out == 2'b01) || (wEnMemPipeEx_Out == 2'b10);
    assign is_load      = memoryMuxSelPipeEx_Out && !is_store;
    assign is_vec       = (wEnMemPipeEx_Out == 2'b10) || (is_load && readModeMemPipeEx_Out);
    assign memop        = is_store || memoryMuxSelPipeEx_Out;
    assign addr_aligned = {aluRes_pipeExOut[ADDR_W-1:2], 2'b00};

    // Instruction captured at the start of a memory access
    logic [1:0]  wen_reg_p1;
    logic [3:0]  rd_p1;
    logic [63:0] alu_p1;
    logic [31:0] wdata_hi_p1;
    logic        load_p1;
    logic        vec_p1;
    logic [31:0] rdata0_p1;
    logic [31:0] rdata1_p1;

    // Writeback value for a completed access: loaded data or the ALU result
    function automatic logic [63:0] access_result(
        input logic        ld,
        input logic        vec,
        input logic [31:0] r0,
        input logic [31:0] r1,
        input logic [63:0] alu
    );
        if (!ld)
            return alu;
        else if (vec)
            return {r1, r0};
        else
            return {32'h0, r0};
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and stall decode
    always_comb begin
        state_nxt = state;
        memStall  = 1'b0;
        case (state)
            IDLE: begin
                if (memop) begin
                    memStall  = 1'b1;
                    state_nxt = BEAT0;
                end
            end
            BEAT0: begin
                memStall = 1'b1;
                if (memAck)
                    state_nxt = vec_p1 ? BEAT1 : DONE;
            end
            BEAT1: begin
                memStall = 1'b1;
                if (memAck)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus outputs: set up a beat on entry, advance to the second word on ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        memReq   <= 1'b1;
                        memWe    <= is_store;
                        memAddr  <= addr_aligned;
                        memWdata <= regData2_pipeExOut[31:0];
                    end
                end
                BEAT0: begin
                    if (memAck) begin
                        if (vec_p1) begin
                            memAddr  <= memAddr + ADDR_W'(4);
                            memWdata <= wdata_hi_p1;
                        end else begin
                            memReq <= 1'b0;
                        end
                    end
                end
                BEAT1: begin
                    if (memAck)
                        memReq <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Capture the instruction on access start and latch read data on each ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_reg_p1  <= '0;
            rd_p1       <= '0;
            alu_p1      <= '0;
            wdata_hi_p1 <= '0;
            load_p1     <= 1'b0;
            vec_p1      <= 1'b0;
            rdata0_p1   <= '0;
            rdata1_p1   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        wen_reg_p1  <= wEnRegPipeEx_Out;
                        rd_p1       <= rdPipeEx_Out;
                        alu_p1      <= aluRes_pipeExOut;
                        wdata_hi_p1 <= regData2_pipeExOut[63:32];
                        load_p1     <= is_load;
                        vec_p1      <= is_vec;
                    end
                end
                BEAT0: if (memAck) rdata0_p1 <= memRdata;
                BEAT1: if (memAck) rdata1_p1 <= memRdata;
                default: ;
            endcase
        end
    end

    // MEM/WB register: pass-through, bubble while busy, result in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wEnRegPipeMem_Out <= '0;
            rdPipeMem_Out     <= '0;
            wbDataPipeMem_Out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        wEnRegPipeMem_Out <= '0;
                        rdPipeMem_Out     <= '0;
                        wbDataPipeMem_Out <= '0;
                    end else begin
                        wEnRegPipeMem_Out <= wEnRegPipeEx_Out;
                        rdPipeMem_Out     <= rdPipeEx_Out;
                        wbDataPipeMem_Out <= aluRes_pipeExOut;
                    end
                end
                DONE: begin
                    wEnRegPipeMem_Out <= wen_reg_p1;
                    rdPipeMem_Out     <= rd_p1;
                    wbDataPipeMem_Out <= access_result(load_p1, vec_p1, rdata0_p1,
                                                       rdata1_p1, alu_p1);
                end
                default: begin
                    wEnRegPipeMem_Out <= '0;
                    rdPipeMem_Out     <= '0;
                    wbDataPipeMem_Out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_memory_stage.sv
// Testbench for pipeline_memory_stage: directed steps followed by randomized
// instructions, each checked against a transaction-level reference model.
module tb_pipeline_memory_stage;

    logic        clk;
    logic        rst;
    logic [1:0]  wEnMem;
    logic [1:0]  wEnReg;
    logic [3:0]  rdIn;
    logic        memSel;
    logic        readMode;
    logic [63:0] aluRes;
    logic [63:0] regData2;
    logic        memStall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memAck;
    logic [31:0] memRdata;
    logic [1:0]  wEnRegOut;
    logic [3:0]  rdOut;
    logic [63:0] wbData;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_memory_stage #(.ADDR_W(32)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .wEnMemPipeEx_Out       (wEnMem),
        .wEnRegPipeEx_Out       (wEnReg),
        .rdPipeEx_Out           (rdIn),
        .memoryMuxSelPipeEx_Out (memSel),
        .readModeMemPipeEx_Out  (readMode),
        .aluRes_pipeExOut       (aluRes),
        .regData2_pipeExOut     (regData2),
        .memStall               (memStall),
        .memReq                 (memReq),
        .memWe                  (memWe),
        .memAddr                (memAddr),
        .memWdata               (memWdata),
        .memAck                 (memAck),
        .memRdata               (memRdata),
        .wEnRegPipeMem_Out      (wEnRegOut),
        .rdPipeMem_Out          (rdOut),
        .wbDataPipeMem_Out      (wbData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wEnMem   = 2'b00;
        wEnReg   = 2'b00;
        rdIn     = 4'h0;
        memSel   = 1'b0;
        readMode = 1'b0;
        aluRes   = 64'h0;
        regData2 = 64'h0;
    endtask

    // Presents one instruction (starting 1 time unit after a rising edge),
    // acts as the data memory with `dly` wait cycles per beat, and checks the
    // bus beats, stall behaviour, latency and the MEM/WB result.
    task automatic run_instr(input logic [1:0] wm, input logic [1:0] wr, input logic [3:0] rdv,
                             input logic ms, input logic rm, input logic [63:0] alu,
                             input logic [63:0] d2, input int dly,
                             input logic [31:0] r0, input logic [31:0] r1);
        logic        st, ld, vec, mop;
        int          nb, beat, waited, cycles, idx;
        logic [31:0] ba [2];
        logic [31:0] wd [2];
        logic [31:0] rv [2];
        logic [63:0] exp_wb;
        bit          done;

        // Reference model of the whole transaction
        st  = (wm == 2'b01) || (wm == 2'b10);
        ld  = ms && !st;
        vec = (wm == 2'b10) || (ld && rm);
        mop = st || ms;
        nb  = mop ? (vec ? 2 : 1) : 0;
        ba[0] = alu[31:0] - (alu[31:0] % 32'd4);
        ba[1] = ba[0] + 32'd4;
        wd[0] = d2[31:0];
        wd[1] = d2[63:32];
        rv[0] = r0;
        rv[1] = r1;
        if (!ld)      exp_wb = alu;
        else if (vec) exp_wb = {r1, r0};
        else          exp_wb = {32'h0, r0};

        wEnMem = wm; wEnReg = wr; rdIn = rdv; memSel = ms; readMode = rm;
        aluRes = alu; regData2 = d2;
        memAck   = 1'($urandom_range(0, 1));
        memRdata = $urandom;
        #1;
        chk("stall_present", 64'(memStall), 64'(mop));

        if (!mop) begin
            tick();
            chk("pt_wen", 64'(wEnRegOut), 64'(wr));
            chk("pt_rd", 64'(rdOut), 64'(rdv));
            chk("pt_data", wbData, alu);
            memAck = 1'b0;
            return;
        end

        beat = 0; waited = 0; cycles = 0; done = 0;
        while (!done && cycles < 60) begin
            tick();
            cycles++;
            memAck   = 1'b0;
            memRdata = $urandom;
            if (memReq) begin
                idx = (beat > 1) ? 1 : beat;
                chk("beat_in_range", 64'(beat < nb), 64'(1));
                chk("beat_addr", 64'(memAddr), 64'(ba[idx]));
                chk("beat_we", 64'(memWe), 64'(st));
                if (st) chk("beat_wdata", 64'(memWdata), 64'(wd[idx]));
                chk("beat_stall", 64'(memStall), 64'(1));
                chk("beat_bubble_wen", 64'(wEnRegOut), 64'(0));
                if (waited < dly) begin
                    waited++;
                end else begin
                    memAck   = 1'b1;
                    memRdata = rv[idx];
                    beat++;
                    waited = 0;
                end
            end else begin
                chk("beats_done", 64'(beat), 64'(nb));
                chk("latency", 64'(cycles), 64'(nb * (dly + 1) + 1));
                chk("done_stall", 64'(memStall), 64'(0));
                memAck = 1'($urandom_range(0, 1));
                tick();
                memAck = 1'b0;
                chk("wb_wen", 64'(wEnRegOut), 64'(wr));
                chk("wb_rd", 64'(rdOut), 64'(rdv));
                chk("wb_data", wbData, exp_wb);
                done = 1;
            end
        end
        n_cmp++;
        assert (done)
        else begin
            n_err++;
            $error("FAIL timeout: observed %0d cycles without completion expected %0d", cycles, nb * (dly + 1) + 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        memAck   = 1'b0;
        memRdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_req", 64'(memReq), 64'(0));
        chk("rst_we", 64'(memWe), 64'(0));
        chk("rst_addr", 64'(memAddr), 64'(0));
        chk("rst_wdata", 64'(memWdata), 64'(0));
        chk("rst_wen", 64'(wEnRegOut), 64'(0));
        chk("rst_rd", 64'(rdOut), 64'(0));
        chk("rst_wb", wbData, 64'(0));
        chk("rst_stall", 64'(memStall), 64'(0));
        rst = 1'b0;

        // Pass-through
        run_instr(2'b00, 2'b01, 4'd5, 1'b0, 1'b0, 64'h1234, 64'h0, 0, 32'h0, 32'h0);
        // Reserved store type behaves as no memory operation
        run_instr(2'b11, 2'b10, 4'd9, 1'b0, 1'b1, 64'hCAFE_0000_1111_2222, 64'h55, 0, 32'h0, 32'h0);
        // Scalar load, immediate ack
        run_instr(2'b00, 2'b01, 4'd3, 1'b1, 1'b0, 64'h100, 64'h0, 0, 32'hDEADBEEF, 32'h0);
        // Vector store with two wait cycles per beat
        run_instr(2'b10, 2'b00, 4'd0, 1'b0, 1'b0, 64'h0FFC, 64'hAABBCCDD_11223344, 2, 32'h0, 32'h0);
        // Vector load across address wrap, unaligned address
        run_instr(2'b00, 2'b11, 4'd7, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFD, 64'h0, 0,
                  32'h0BAD_F00D, 32'h1357_9BDF);
        // Store plus memoryMuxSel: single write beat, ALU result written back
        run_instr(2'b01, 2'b01, 4'd12, 1'b1, 1'b1, 64'h0000_0042_0000_0208, 64'h9999_8888_7777_6666, 1,
                  32'h1111_1111, 32'h2222_2222);

        // Reset during BEAT1 of a vector store aborts it immediately
        wEnMem = 2'b10; wEnReg = 2'b01; rdIn = 4'd4; memSel = 1'b0; readMode = 1'b0;
        aluRes = 64'h2000; regData2 = 64'h0123_4567_89AB_CDEF;
        memAck = 1'b0;
        tick();
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        chk("pre_rst_req", 64'(memReq), 64'(1));
        chk("pre_rst_addr", 64'(memAddr), 64'h2004);
        #2;
        rst = 1'b1;
        clear_inputs();
        #1;
        chk("midrst_req", 64'(memReq), 64'(0));
        chk("midrst_we", 64'(memWe), 64'(0));
        chk("midrst_addr", 64'(memAddr), 64'(0));
        chk("midrst_wdata", 64'(memWdata), 64'(0));
        chk("midrst_wen", 64'(wEnRegOut), 64'(0));
        chk("midrst_wb", wbData, 64'(0));
        chk("midrst_stall", 64'(memStall), 64'(0));
        tick();
        rst = 1'b0;
        // Next instruction starts cleanly from IDLE
        run_instr(2'b00, 2'b10, 4'd8, 1'b1, 1'b0, 64'h0000_0000_0000_0344, 64'h0, 0, 32'hFEED_FACE, 32'h0);

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            run_instr(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3),
                      $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
